conv1_frame_ctrl: RTL
=====================

Name: conv1_frame_ctrl

Overview:
Frame sequencer for the conv1 layer datapath.
- Fetches one image frame, 32-bit words of 4 pixels each, from an image SRAM.
- Streams the words into the conv1 line buffer with the data_valid, sof and eof framing conv1 expects.
- Counts pool-valid strobes returned by conv1 and signals frame completion, or a timeout error if the pool outputs never arrive.

Parameters:
- DATA_WIDTH, 32, image word width (4 x 8-bit pixels)
- IMG_NUM_WORDS, 256, words per frame (32x32 image)
- ADDR_WIDTH, 8, image SRAM address width; must satisfy 2^ADDR_WIDTH >= IMG_NUM_WORDS
- POOL_VALID_CNT, 98, pool_valid strobes expected per frame (14x14 pooled / 2 pixels per strobe)
- POOL_CNT_WIDTH, 7, width of the pool counter
- DRAIN_TIMEOUT, 1024, max DRAIN cycles before error
- TMO_WIDTH, 10, width of the timeout counter

Ports:
- conv1_ctrl_clk  in  1  clock
- conv1_ctrl_rst_b  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle frame start request
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle frame-complete pulse
- err_timeout_o  out  1  sticky; set on drain timeout, cleared by the next accepted start
- img_rd_en_o  out  1  image SRAM read enable
- img_rd_addr_o  out  ADDR_WIDTH  image SRAM read address
- img_rd_data_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after img_rd_en_o
- conv1_data_valid_o  out  1  word valid to conv1
- conv1_lb_in_o  out  DATA_WIDTH  word to the conv1 line buffer
- sof_o  out  1  start of frame, coincident with word 0
- eof_o  out  1  end-of-frame pulse
- pool_valid_i  in  1  pool output strobe from conv1
- pool_cnt_o  out  POOL_CNT_WIDTH  pool strobes counted this frame

Behaviour:
- Reset values:
  - All outputs 0; conv1_lb_in_o is 0.
  - State is IDLE.
  - Address, pool and timeout counters are 0.
- Reset asserted mid-frame aborts immediately; nothing resumes after release.
- States: IDLE, STREAM, EOF, DRAIN, DONE.
- IDLE:
  - start_i=1 goes to STREAM.
  - On the same edge: address, pool_cnt_o, timeout counter and err_timeout_o are cleared.
- STREAM:
  - img_rd_en_o=1, img_rd_addr_o=k, for k = 0 .. IMG_NUM_WORDS-1, one address per cycle, back to back.
  - The edge after issuing address IMG_NUM_WORDS-1 goes to EOF.
- Read pipeline (fixed 2-cycle issue-to-output latency):
  - Data for address k arrives 1 cycle after issue.
  - It is registered into conv1_lb_in_o with conv1_data_valid_o=1 on the following edge.
  - sof_o=1 only in the cycle word 0 is presented.
  - conv1_lb_in_o holds its last value when valid is low.
- EOF:
  - Waits for the last word to leave the pipeline.
  - eof_o pulses exactly 1 cycle, the cycle immediately after the last data_valid, with data_valid=0.
  - Then goes to DRAIN.
- pool_valid_i counting:
  - Counted in STREAM, EOF and DRAIN.
  - The counter saturates at 2^POOL_CNT_WIDTH-1.
  - Ignored in IDLE and DONE.
- DRAIN:
  - pool_cnt_o >= POOL_VALID_CNT goes to DONE. A strobe on the final counting cycle counts before the compare.
  - Otherwise the timeout counter increments each cycle.
  - When the timeout counter reaches DRAIN_TIMEOUT-1: set err_timeout_o and go to DONE.
- DONE:
  - done_o=1 for 1 cycle, busy_o=0 in that same cycle, then IDLE.
  - pool_cnt_o and err_timeout_o hold until the next start.
- start_i while not IDLE is ignored, with no queueing.

Optional Feature:
- Macro: CONV1_CTRL_STALL_EN.
- When defined:
  - Adds input port stall_i (1 bit).
  - In STREAM, stall_i=1 forces img_rd_en_o=0 and holds the address.
  - Words already in the pipeline still emerge, so conv1_data_valid_o shows gaps equal to the stall cycles.
  - sof_o and eof_o rules are unchanged; eof_o still follows the final valid word by 1 cycle.
  - stall_i is ignored outside STREAM.
- When undefined: no port, and streaming is never interrupted.

Test Plan:
- Nominal frame:
  - Stimulus: start_i pulse at cycle 0; SRAM preloaded with word[k]=k.
  - Address checks: rd_addr 0..255 in cycles 1..256.
  - Data checks: data_valid in cycles 3..258, carrying 0..255; sof_o only at cycle 3; eof_o only at cycle 259.
  - Completion: 98 pool_valid pulses during DRAIN give done_o 1 cycle after the 98th, pool_cnt_o=98, err_timeout_o=0.
- Timeout: run a frame with no pool_valid_i. err_timeout_o=1 and done_o fire 1024 cycles after DRAIN entry. The next start clears err_timeout_o.
- Start while busy: extra start_i pulses at cycles 50 and 260 produce no restart; the address sequence is unbroken and there is exactly one done_o.
- Reset mid-frame: assert rst_b=0 at cycle 100. All outputs go to 0 asynchronously, and the block stays IDLE after release until a new start.
- Pool counting edge: pool_valid_i high during STREAM for 10 cycles, then 88 in DRAIN, gives done after the 88th DRAIN strobe. Strobes after done_o do not change pool_cnt_o.
- With CONV1_CTRL_STALL_EN: stall_i=1 for 5 cycles at cycle 20 holds the address. data_valid shows a 5-cycle gap, total valid words are still 256 in order, and eof_o is shifted by 5 cycles to cycle 264.

Source files
------------

// File: rtl/conv1_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv1_frame_ctrl
//  Purpose  : Frame sequencer for conv1: streams one image frame from SRAM into
//             the line buffer with sof/eof framing, then counts pool strobes.
//  Option   : CONV1_CTRL_STALL_EN adds stall_i to pause SRAM reads in STREAM.
//  Revision : 1.0 - initial release
// ============================================================================
module conv1_frame_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int IMG_NUM_WORDS  = 256,
    parameter int ADDR_WIDTH     = 8,
    parameter int POOL_VALID_CNT = 98,
    parameter int POOL_CNT_WIDTH = 7,
    parameter int DRAIN_TIMEOUT  = 1024,
    parameter int TMO_WIDTH      = 10
) (
    input  logic                      conv1_ctrl_clk,
    input  logic                      conv1_ctrl_rst_b,
    input  logic                      start_i,
`ifdef CONV1_CTRL_STALL_EN
    input  logic                      stall_i,
`endif
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_timeout_o,
    output logic                      img_rd_en_o,
    output logic [ADDR_WIDTH-1:0]     img_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]     img_rd_data_i,
    output logic                      conv1_data_valid_o,
    output logic [DATA_WIDTH-1:0]     conv1_lb_in_o,
    output logic                      sof_o,
    output logic                      eof_o,
    input  logic                      pool_valid_i,
    output logic [POOL_CNT_WIDTH-1:0] pool_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_EOF    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR = ADDR_WIDTH'(IMG_NUM_WORDS - 1);
    localparam logic [POOL_CNT_WIDTH-1:0] POOL_TGT  = POOL_CNT_WIDTH'(POOL_VALID_CNT);
    localparam logic [POOL_CNT_WIDTH-1:0] POOL_MAX  = '1;
    localparam logic [TMO_WIDTH-1:0]      TMO_LAST  = TMO_WIDTH'(DRAIN_TIMEOUT - 1);

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [POOL_CNT_WIDTH-1:0] pool_cnt_q, pool_cnt_d;
    logic [TMO_WIDTH-1:0]      tmo_q, tmo_d;
    logic                      err_q, err_d;

    // Read pipeline: issue -> SRAM data -> registered line-buffer word.
    logic                      rd_vld_q, rd_first_q, rd_last_q;
    logic                      vld_q, vld_last_q, sof_q, eof_q;
    logic [DATA_WIDTH-1:0]     lb_q;

    logic                      rd_issue;
    logic                      done;
    logic                      stall;

`ifdef CONV1_CTRL_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pool_cnt_d = pool_cnt_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        rd_issue   = 1'b0;
        done       = 1'b0;

        if ((state_q == S_STREAM || state_q == S_EOF || state_q == S_DRAIN) &&
            pool_valid_i && (pool_cnt_q != POOL_MAX)) begin
            pool_cnt_d = pool_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_STREAM;
                    addr_d     = '0;
                    pool_cnt_d = '0;
                    tmo_d      = '0;
                    err_d      = 1'b0;
                end
            end
            S_STREAM: begin
                if (!stall) begin
                    rd_issue = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_EOF;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_EOF: begin
                if (eof_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // pool_cnt_d already includes this cycle's strobe.
                if (pool_cnt_d >= POOL_TGT) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge conv1_ctrl_clk or negedge conv1_ctrl_rst_b) begin
        if (!conv1_ctrl_rst_b) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pool_cnt_q <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            vld_q      <= 1'b0;
            vld_last_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            lb_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pool_cnt_q <= pool_cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            rd_vld_q   <= rd_issue;
            rd_first_q <= rd_issue && (addr_q == '0);
            rd_last_q  <= rd_issue && (addr_q == LAST_ADDR);
            vld_q      <= rd_vld_q;
            vld_last_q <= rd_last_q;
            sof_q      <= rd_first_q;
            eof_q      <= vld_last_q;
            if (rd_vld_q) begin
                lb_q <= img_rd_data_i;
            end
        end
    end

    assign busy_o             = (state_q == S_STREAM) || (state_q == S_EOF) ||
                                (state_q == S_DRAIN);
    assign done_o             = done;
    assign err_timeout_o      = err_q;
    assign img_rd_en_o        = rd_issue;
    assign img_rd_addr_o      = addr_q;
    assign conv1_data_valid_o = vld_q;
    assign conv1_lb_in_o      = lb_q;
    assign sof_o              = sof_q;
    assign eof_o              = eof_q;
    assign pool_cnt_o         = pool_cnt_q;

endmodule
`default_nettype wire
